// File: rtl/shot_controller_if.sv
// Bundle of board, mouse and shot-result signals between the top FSM / video
// side (master) and shot_controller (slave).
//   master drives : program_state, mouse_xpos/ypos, mouse_left, player1/2_placing_board
//   slave drives  : player1/2_findings_board, active_player, shot_valid, shot_hit,
//                   shot_index, hits_p1, hits_p2, blank_req, game_over, winner
interface shot_controller_if;
   localparam int unsigned STATE_W = 4;
   localparam int unsigned POS_W   = 12;
   localparam int unsigned BOARD_W = 64;
   localparam int unsigned IDX_W   = 6;
   localparam int unsigned HIT_W   = 5;

   logic [STATE_W-1:0] program_state;
   logic [POS_W-1:0]   mouse_xpos;
   logic [POS_W-1:0]   mouse_ypos;
   logic               mouse_left;
   logic [BOARD_W-1:0] player1_placing_board;
   logic [BOARD_W-1:0] player2_placing_board;
   logic [BOARD_W-1:0] player1_findings_board;
   logic [BOARD_W-1:0] player2_findings_board;
   logic               active_player;
   logic               shot_valid;
   logic               shot_hit;
   logic [IDX_W-1:0]   shot_index;
   logic [HIT_W-1:0]   hits_p1;
   logic [HIT_W-1:0]   hits_p2;
   logic               blank_req;
   logic               game_over;
   logic               winner;

   modport master (
      output program_state, mouse_xpos, mouse_ypos, mouse_left,
             player1_placing_board, player2_placing_board,
      input  player1_findings_board, player2_findings_board, active_player,
             shot_valid, shot_hit, shot_index, hits_p1, hits_p2,
             blank_req, game_over, winner
   );

   modport slave (
      input  program_state, mouse_xpos, mouse_ypos, mouse_left,
             player1_placing_board, player2_placing_board,
      output player1_findings_board, player2_findings_board, active_player,
             shot_valid, shot_hit, shot_index, hits_p1, hits_p2,
             blank_req, game_over, winner
   );
endinterface

// File: rtl/shot_controller.sv
// Turn/shot engine for the FINDING_SHIPS phase: decodes a left click into a
// board square, records the shot, resolves hit/miss, alternates players
// through a blanking interval and declares the winner.
// Ports:
//   clk  - pixel clock, all logic on posedge
//   rst  - synchronous reset, active-low
//   bus  - shot_controller_if.slave (mouse/board inputs, shot results out)
module shot_controller #(
   parameter int unsigned BOARD_XPOS   = 40,
   parameter int unsigned BOARD_YPOS   = 40,
   parameter int unsigned SQUARE_SIZE  = 40,
   parameter int unsigned SHIP_CELLS   = 15,
   parameter int unsigned BLANK_CYCLES = 65_000_000
) (
   input logic              clk,
   input logic              rst,
   shot_controller_if.slave bus
);
   localparam int unsigned POS_W   = 12;
   localparam int unsigned HIT_W   = 5;
   localparam int unsigned BOARD_W = 64;
   localparam int unsigned CNT_W   = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam int unsigned X_END   = BOARD_XPOS + 8 * SQUARE_SIZE;
   localparam int unsigned Y_END   = BOARD_YPOS + 8 * SQUARE_SIZE;

   localparam logic [3:0] PLACING_SHIPS  = 4'b0011;
   localparam logic [3:0] FINDING_SHIPS  = 4'b0100;
   localparam logic [3:0] FINDING_SHIPS2 = 4'b0101;

   typedef enum logic [2:0] {IDLE, WAIT_CLICK, DECODE, CHECK, BLANK, DONE} state_t;

   state_t             state, state_next;
   logic [3:0]         prev_state;
   logic               mouse_left_d;
   logic [POS_W-1:0]   x_q, y_q;
   logic [2:0]         col_q, row_q;
   logic [CNT_W-1:0]   blank_cnt;
   logic [BOARD_W-1:0] p1_findings, p2_findings;
   logic               active_player, shot_valid, shot_hit;
   logic [5:0]         shot_index;
   logic [HIT_W-1:0]   hits_p1, hits_p2;
   logic               blank_req, game_over, winner;

   logic               entry_c, in_phase_c, click_c;
   logic               x_in_c, y_in_c;
   logic [2:0]         col_c, row_c;
   logic [5:0]         idx_c;
   logic               already_c, hit_c, win_c, blank_done_c;
   logic [HIT_W-1:0]   shooter_hits_c, new_hits_c;

   // Phase tracking and click edge
   assign entry_c    = (prev_state == PLACING_SHIPS) && (bus.program_state == FINDING_SHIPS);
   assign in_phase_c = (bus.program_state == FINDING_SHIPS) || (bus.program_state == FINDING_SHIPS2);
   assign click_c    = bus.mouse_left & ~mouse_left_d;

   // Square decode: thermometer of boundary comparators instead of a divider
   always_comb begin
      x_in_c = (32'(x_q) >= BOARD_XPOS) && (32'(x_q) < X_END);
      y_in_c = (32'(y_q) >= BOARD_YPOS) && (32'(y_q) < Y_END);
      col_c  = 3'd0;
      row_c  = 3'd0;
      for (int unsigned k = 1; k < 8; k++) begin
         if (32'(x_q) >= BOARD_XPOS + k * SQUARE_SIZE) col_c = 3'(k);
         if (32'(y_q) >= BOARD_YPOS + k * SQUARE_SIZE) row_c = 3'(k);
      end
   end

   // Shot resolution against the shooter's findings and the opponent's ships
   always_comb begin
      idx_c          = {row_q, col_q};
      already_c      = active_player ? p2_findings[idx_c] : p1_findings[idx_c];
      hit_c          = active_player ? bus.player1_placing_board[idx_c]
                                     : bus.player2_placing_board[idx_c];
      shooter_hits_c = active_player ? hits_p2 : hits_p1;
      new_hits_c     = (shooter_hits_c >= HIT_W'(SHIP_CELLS)) ? shooter_hits_c
                                                              : shooter_hits_c + HIT_W'(1);
      win_c          = hit_c && (new_hits_c == HIT_W'(SHIP_CELLS));
      blank_done_c   = (blank_cnt == CNT_W'(BLANK_CYCLES - 1));
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      if (entry_c) begin
         state_next = WAIT_CLICK;
      end else if (!in_phase_c) begin
         state_next = IDLE;
      end else begin
         case (state)
            WAIT_CLICK: if (click_c) state_next = DECODE;
            DECODE:     state_next = (x_in_c && y_in_c) ? CHECK : WAIT_CLICK;
            CHECK: begin
               if (already_c)  state_next = WAIT_CLICK;
               else if (!hit_c) state_next = BLANK;
               else if (win_c)  state_next = DONE;
               else             state_next = WAIT_CLICK;
            end
            BLANK:      if (blank_done_c) state_next = WAIT_CLICK;
            default:    state_next = state;
         endcase
      end
   end

   // Datapath and registered outputs; leaving the phase freezes everything
   always_ff @(posedge clk) begin
      if (!rst) begin
         prev_state    <= '0;
         mouse_left_d  <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         col_q         <= '0;
         row_q         <= '0;
         blank_cnt     <= '0;
         p1_findings   <= '0;
         p2_findings   <= '0;
         active_player <= 1'b0;
         shot_valid    <= 1'b0;
         shot_hit      <= 1'b0;
         shot_index    <= '0;
         hits_p1       <= '0;
         hits_p2       <= '0;
         blank_req     <= 1'b0;
         game_over     <= 1'b0;
         winner        <= 1'b0;
      end else begin
         prev_state   <= bus.program_state;
         mouse_left_d <= bus.mouse_left;
         shot_valid   <= 1'b0;
         if (entry_c) begin
            p1_findings   <= '0;
            p2_findings   <= '0;
            hits_p1       <= '0;
            hits_p2       <= '0;
            shot_hit      <= 1'b0;
            shot_index    <= '0;
            active_player <= 1'b0;
            game_over     <= 1'b0;
            winner        <= 1'b0;
            blank_req     <= 1'b0;
            blank_cnt     <= '0;
         end else if (in_phase_c) begin
            case (state)
               WAIT_CLICK: begin
                  if (click_c) begin
                     x_q <= bus.mouse_xpos;
                     y_q <= bus.mouse_ypos;
                  end
               end
               DECODE: begin
                  col_q <= col_c;
                  row_q <= row_c;
               end
               CHECK: begin
                  if (!already_c) begin
                     if (active_player) p2_findings[idx_c] <= 1'b1;
                     else               p1_findings[idx_c] <= 1'b1;
                     shot_index <= idx_c;
                     shot_hit   <= hit_c;
                     shot_valid <= 1'b1;
                     if (hit_c) begin
                        if (active_player) hits_p2 <= new_hits_c;
                        else               hits_p1 <= new_hits_c;
                        if (win_c) begin
                           game_over <= 1'b1;
                           winner    <= active_player;
                        end
                     end else begin
                        blank_req <= 1'b1;
                        blank_cnt <= '0;
                     end
                  end
               end
               BLANK: begin
                  // blank_req drops in the same cycle the turn passes
                  if (blank_done_c) begin
                     blank_req     <= 1'b0;
                     active_player <= ~active_player;
                  end else begin
                     blank_cnt <= blank_cnt + CNT_W'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.player1_findings_board = p1_findings;
   assign bus.player2_findings_board = p2_findings;
   assign bus.active_player          = active_player;
   assign bus.shot_valid             = shot_valid;
   assign bus.shot_hit               = shot_hit;
   assign bus.shot_index             = shot_index;
   assign bus.hits_p1                = hits_p1;
   assign bus.hits_p2                = hits_p2;
   assign bus.blank_req              = blank_req;
   assign bus.game_over              = game_over;
   assign bus.winner                 = winner;
endmodule

// File: tb/tb_shot_controller.sv
// Directed bench for shot_controller: table of clicks with hand-computed
// results, plus sequences for held button, win, and reset during blanking.
module tb_shot_controller;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   shot_controller_if bus();

   shot_controller #(.BLANK_CYCLES(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         x;
      int         y;
      logic       valid;
      logic [5:0] idx;
      logic       hit;
      logic [4:0] hp1;
      logic [4:0] hp2;
      int         blanks;
      logic       player;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drop_btn();
      @(negedge clk);
      bus.mouse_left = 1'b0;
   endtask

   task automatic press(input int x, input int y);
      @(negedge clk);
      bus.mouse_xpos = 12'(x);
      bus.mouse_ypos = 12'(y);
      bus.mouse_left = 1'b1;
   endtask

   // Fresh press, then land just after the edge that publishes the result (E+3)
   task automatic click(input int x, input int y);
      drop_btn();
      press(x, y);
      repeat (3) @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] small_outs();
      return 64'({bus.active_player, bus.shot_valid, bus.shot_hit, bus.shot_index,
                  bus.hits_p1, bus.hits_p2, bus.blank_req, bus.game_over, bus.winner});
   endfunction

   initial begin
      int   nblank;
      int   extra_valid;
      logic prev_b;
      int   sq [12];

      vecs[0] = '{130,  90, 1'b1, 6'd10, 1'b1, 5'd1, 5'd0, 0, 1'b0};
      vecs[1] = '{130,  90, 1'b0, 6'd0,  1'b0, 5'd1, 5'd0, 0, 1'b0};
      vecs[2] = '{360,  90, 1'b0, 6'd0,  1'b0, 5'd1, 5'd0, 0, 1'b0};
      vecs[3] = '{ 40,  40, 1'b1, 6'd0,  1'b0, 5'd1, 5'd0, 4, 1'b1};
      vecs[4] = '{ 39,  40, 1'b0, 6'd0,  1'b0, 5'd1, 5'd0, 0, 1'b1};
      vecs[5] = '{ 40,  40, 1'b1, 6'd0,  1'b1, 5'd1, 5'd1, 0, 1'b1};
      vecs[6] = '{359,  79, 1'b1, 6'd7,  1'b1, 5'd1, 5'd2, 0, 1'b1};
      vecs[7] = '{ 40, 360, 1'b0, 6'd0,  1'b0, 5'd1, 5'd2, 0, 1'b1};
      vecs[8] = '{359, 359, 1'b1, 6'd63, 1'b0, 5'd1, 5'd2, 4, 1'b0};
      sq = '{2, 3, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14};

      bus.program_state         = 4'd0;
      bus.mouse_xpos            = '0;
      bus.mouse_ypos            = '0;
      bus.mouse_left            = 1'b0;
      bus.player1_placing_board = 64'h0000_0000_0000_7FFF;
      bus.player2_placing_board = 64'h0000_0000_0000_0400;

      repeat (3) @(posedge clk);
      #1;
      check("reset p1 findings", bus.player1_findings_board, 64'h0);
      check("reset p2 findings", bus.player2_findings_board, 64'h0);
      check("reset outputs", small_outs(), 64'h0);

      @(negedge clk);
      rst = 1'b1;
      bus.program_state = 4'b0011;
      repeat (2) @(negedge clk);
      bus.program_state = 4'b0100;

      for (int i = 0; i < 9; i++) begin
         click(vecs[i].x, vecs[i].y);
         check($sformatf("v%0d shot_valid", i), 64'(bus.shot_valid), 64'(vecs[i].valid));
         if (vecs[i].valid) begin
            check($sformatf("v%0d shot_index", i), 64'(bus.shot_index), 64'(vecs[i].idx));
            check($sformatf("v%0d shot_hit", i), 64'(bus.shot_hit), 64'(vecs[i].hit));
         end
         nblank = int'(bus.blank_req);
         @(posedge clk);
         #1;
         check($sformatf("v%0d pulse width", i), 64'(bus.shot_valid), 64'h0);
         nblank += int'(bus.blank_req);
         repeat (6) begin
            @(posedge clk);
            #1;
            nblank += int'(bus.blank_req);
         end
         check($sformatf("v%0d blank cycles", i), 64'(nblank), 64'(vecs[i].blanks));
         check($sformatf("v%0d hits_p1", i), 64'(bus.hits_p1), 64'(vecs[i].hp1));
         check($sformatf("v%0d hits_p2", i), 64'(bus.hits_p2), 64'(vecs[i].hp2));
         check($sformatf("v%0d active_player", i), 64'(bus.active_player), 64'(vecs[i].player));
      end
      check("table p1 findings", bus.player1_findings_board, 64'h0000_0000_0000_0401);
      check("table p2 findings", bus.player2_findings_board, 64'h8000_0000_0000_0081);

      // Player1 misses and keeps the button down through the turn change
      click(90, 40);
      check("held shot_valid", 64'(bus.shot_valid), 64'h1);
      check("held shot_index", 64'(bus.shot_index), 64'd1);
      check("held shot_hit", 64'(bus.shot_hit), 64'h0);
      prev_b      = bus.blank_req;
      extra_valid = 0;
      repeat (14) begin
         @(posedge clk);
         #1;
         if (prev_b && !bus.blank_req)
            check("player at blank fall", 64'(bus.active_player), 64'h1);
         extra_valid += int'(bus.shot_valid);
         prev_b = bus.blank_req;
      end
      check("held no extra shot", 64'(extra_valid), 64'h0);
      check("held active_player", 64'(bus.active_player), 64'h1);
      check("held p2 findings", bus.player2_findings_board, 64'h8000_0000_0000_0081);
      check("held p1 findings", bus.player1_findings_board, 64'h0000_0000_0000_0403);

      click(90, 40);
      check("p2 idx1 valid", 64'(bus.shot_valid), 64'h1);
      check("p2 idx1 hit", 64'(bus.shot_hit), 64'h1);
      check("p2 idx1 hits_p2", 64'(bus.hits_p2), 64'd3);

      // Player2 sinks the remaining cells; the last one wins
      for (int j = 0; j < 12; j++) begin
         click(60 + 40 * (sq[j] % 8), 60 + 40 * (sq[j] / 8));
         check($sformatf("win%0d valid", j), 64'(bus.shot_valid), 64'h1);
         check($sformatf("win%0d index", j), 64'(bus.shot_index), 64'(sq[j]));
         check($sformatf("win%0d hit", j), 64'(bus.shot_hit), 64'h1);
         check($sformatf("win%0d game_over", j), 64'(bus.game_over), 64'(j == 11));
         repeat (2) @(posedge clk);
      end
      #1;
      check("final hits_p2", 64'(bus.hits_p2), 64'd15);
      check("final winner", 64'(bus.winner), 64'h1);
      check("final p2 findings", bus.player2_findings_board, 64'h8000_0000_0000_7FFF);

      click(340, 60);
      check("after win no shot", 64'(bus.shot_valid), 64'h0);
      check("after win findings", bus.player2_findings_board, 64'h8000_0000_0000_7FFF);
      check("after win game_over", 64'(bus.game_over), 64'h1);

      // New entry clears the game, then reset lands mid-blank
      drop_btn();
      bus.program_state = 4'b0011;
      repeat (2) @(negedge clk);
      bus.program_state = 4'b0100;
      @(posedge clk);
      #1;
      check("entry game_over", 64'(bus.game_over), 64'h0);
      check("entry hits_p2", 64'(bus.hits_p2), 64'h0);
      check("entry p2 findings", bus.player2_findings_board, 64'h0);
      check("entry active_player", 64'(bus.active_player), 64'h0);

      click(60, 60);
      check("pre-reset blank_req", 64'(bus.blank_req), 64'h1);
      check("pre-reset p1 findings", bus.player1_findings_board, 64'h1);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("mid-blank reset p1 findings", bus.player1_findings_board, 64'h0);
      check("mid-blank reset p2 findings", bus.player2_findings_board, 64'h0);
      check("mid-blank reset outputs", small_outs(), 64'h0);
      @(negedge clk);
      rst = 1'b1;
      bus.mouse_left = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end
endmodule
